pn_spike_bank: RTL and testbench
================================

# pn_spike_bank

Multi-channel Poisson spike-train generator built around a bank of parametrised maximal-length LFSRs, one per channel. On every global `tick` each channel advances its LFSR one step and fires a one-cycle spike when the new random value is below that channel's rate threshold, subject to an enable and a programmable refractory period. It sits between the rate/weight configuration registers and the neuron input arbiter. It is the multi-channel, width-generic, reseedable successor to the single 32-bit pseudo-random generator.

## Interface
- `N`, 32, LFSR and rate width; legal values 16, 24, 32 (any other value is a compile-time error)
- `CH`, 4, number of channels, 1..64
- `REF_W`, 4, refractory counter width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `seed`  in  N  base seed, sampled only while `rst`=1
- `tick`  in  1  global time step; 1-cycle pulse, back-to-back allowed
- `en`  in  CH  per-channel spike enable
- `rate`  in  CH*N  per-channel threshold; channel c in bits [c*N +: N]; sampled on tick
- `ref_len`  in  REF_W  refractory length in ticks, shared by all channels, sampled on spike
- `load`  in  1  reseed strobe for one channel
- `load_ch`  in  $clog2(CH) (min 1)  channel to reseed
- `load_seed`  in  N  new LFSR state
- `spike`  out  CH  registered spike pulses
- `num`  out  CH*N  current LFSR state per channel, same packing as `rate`

## Operation
- `INIT` is the low N bits of 0x6BCB769C.
- Fibonacci LFSR: shift left, feedback into bit 0. Feedback is the XOR of these taps, 0-indexed:
  - N=32: 31, 21, 1, 0
  - N=24: 23, 22, 21, 16
  - N=16: 15, 14, 12, 3
- The all-zero state is forbidden. Any value about to be loaded as a state that equals 0 is replaced by `INIT`.
- Reset: `s = INIT ^ seed`, with zero substitution. Channel c state = rotate-left(s, c mod N). All refractory counters = 0. `spike` = 0.
- On `tick`, for every channel c, in parallel:
  - state_c <= lfsr_next(state_c), always, regardless of `en` or refractory.
  - If ref_c != 0: ref_c <= ref_c - 1 and no spike.
  - Else, if en[c] and lfsr_next(state_c) < rate_c (unsigned): spike[c] <= 1 and ref_c <= ref_len.
- `spike[c]` = 0 in every cycle that does not immediately follow a qualifying tick.
- `rate_c` = 0 never fires. `rate_c` = 2^N-1 fires unless the next state is all-ones.
- `ref_len` = 0 means no refractory period.
- `load`: next edge sets state[load_ch] <= load_seed (zero substitution) and ref[load_ch] <= 0.
  - `load_ch` >= CH: ignored.
- Simultaneous `load` and `tick`:
  - The loaded channel takes `load_seed` and does not advance, and its spike bit is 0 for that tick.
  - All other channels tick normally.
- `rst` has priority over `tick` and `load`. Reset mid-operation clears any pending spike on the following edge.

## Timing
- Single clock domain, no handshake back-pressure; `tick` and `load` are never dropped.
- Tick sampled at edge k: `spike` valid in cycle k+1 (after edge k) for exactly one cycle. `num` shows the advanced state from edge k onward.
- Load sampled at edge k: `num` for that channel shows the new state after edge k.
- Reset asserted at edge k: after edge k, `spike` = 0 and `num` = reset states.
- Combinational path per channel: feedback XOR followed by an N-bit comparator. Outputs are fully registered.

## Test plan
- Reset, N=32, CH=2, seed=0:
  - Before any tick: num ch0=0x6BCB769C, ch1=0xD796ED38.
  - After one tick: ch0=0xD796ED38.
- rate=0 on all channels, en=all-ones, 1000 back-to-back ticks -> `spike` never asserts; `num` still advances every tick.
- rate=2^N-1, ref_len=0, en=1:
  - ~every tick produces a spike one cycle later.
  - Then set ref_len=3: consecutive spikes on a channel are at least 4 ticks apart.
- N=16, CH=1, seed=0:
  - Apply 65535 ticks -> state returns to 0x769C.
  - No tick count below 65535 returns it there, and the state is never 0.
- `load` with load_seed=0 on ch1 during an active refractory period:
  - ch1 state=INIT and its refractory is cleared.
  - The same cycle's `tick` advances only the other channels, with spike[1]=0.
- `rst` asserted the cycle after a qualifying tick with seed=0x00000001:
  - The pending spike is cleared.
  - ch0 state=0x6BCB769D.
  - Refractory counters read as 0, checked via an immediate spike on the next qualifying tick.

Source files
------------

// File: rtl/pn_spike_bank.sv
// Multi-channel Poisson spike generator: one maximal-length Fibonacci LFSR per
// channel, compared against a per-channel rate on each tick, with a shared refractory length.
module pn_spike_bank #(
  parameter int N     = 32,
  parameter int CH    = 4,
  parameter int REF_W = 4,
  localparam int LCW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      seed,
  input  logic              tick,
  input  logic [CH-1:0]     en,
  input  logic [CH*N-1:0]   rate,
  input  logic [REF_W-1:0]  ref_len,
  input  logic              load,
  input  logic [LCW-1:0]    load_ch,
  input  logic [N-1:0]      load_seed,
  output logic [CH-1:0]     spike,
  output logic [CH*N-1:0]   num
);

  generate
    if (!(N == 16 || N == 24 || N == 32)) begin : g_bad_n
      $error("pn_spike_bank: N must be 16, 24 or 32");
    end
    if (CH < 1 || CH > 64) begin : g_bad_ch
      $error("pn_spike_bank: CH must be in 1..64");
    end
  endgenerate

  localparam logic [31:0] INIT32 = 32'h6BCB_769C;
  localparam logic [31:0] TAP32  = (N == 32) ? 32'h8020_0003 :
                                   (N == 24) ? 32'h00E1_0000 :
                                               32'h0000_D008;
  localparam logic [N-1:0] INIT  = INIT32[N-1:0];
  localparam logic [N-1:0] TAPS  = TAP32[N-1:0];

  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
    return {s[N-2:0], ^(s & TAPS)};
  endfunction

  // The all-zero state would lock the LFSR, so any zero about to be loaded becomes INIT.
  function automatic logic [N-1:0] nz(input logic [N-1:0] s);
    return (s == '0) ? INIT : s;
  endfunction

  function automatic logic [N-1:0] rotl(input logic [N-1:0] s, input int amt);
    logic [2*N-1:0] dbl;
    dbl = {s, s} << amt;
    return dbl[2*N-1 -: N];
  endfunction

  logic [N-1:0] rst_base;
  assign rst_base = nz(INIT ^ seed);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [N-1:0]     state_q, state_d, adv;
    logic [REF_W-1:0] ref_q, ref_d;
    logic             spike_q, spike_d;
    logic             hit, sel;

    always_comb begin
      adv     = lfsr_next(state_q);
      sel     = load && (int'(load_ch) == c);
      hit     = (ref_q == '0) && en[c] && (adv < rate[c*N +: N]);
      state_d = state_q;
      ref_d   = ref_q;
      spike_d = 1'b0;
      // A reseed wins over a coincident tick for this channel only.
      if (sel) begin
        state_d = nz(load_seed);
        ref_d   = '0;
      end else if (tick) begin
        state_d = adv;
        spike_d = hit;
        if (ref_q != '0) begin
          ref_d = ref_q - 1'b1;
        end else if (hit) begin
          ref_d = ref_len;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= rotl(rst_base, c % N);
        ref_q   <= '0;
        spike_q <= 1'b0;
      end else begin
        state_q <= state_d;
        ref_q   <= ref_d;
        spike_q <= spike_d;
      end
    end

    assign spike[c]       = spike_q;
    assign num[c*N +: N]  = state_q;
  end

endmodule

// File: tb/tb_pn_spike_bank.sv
// Directed bench for pn_spike_bank: a 32-bit 3-channel instance for the functional
// scenarios and a 16-bit single-channel instance for the full-period check.
module tb_pn_spike_bank;
  localparam int N     = 32;
  localparam int CH    = 3;
  localparam int REF_W = 4;
  localparam logic [31:0] INIT = 32'h6BCB_769C;

  logic              clk = 1'b0;
  logic              rst, tick, load;
  logic [N-1:0]      seed, load_seed;
  logic [CH-1:0]     en, spike;
  logic [CH*N-1:0]   rate, num;
  logic [REF_W-1:0]  ref_len;
  logic [1:0]        load_ch;

  logic              rst16, tick16, load16, en16, spike16, load_ch16;
  logic [15:0]       seed16, rate16, load_seed16, num16;
  logic [REF_W-1:0]  ref_len16;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_state [CH];
  int          m_ref   [CH];

  always #5 clk = ~clk;

  pn_spike_bank #(.N(N), .CH(CH), .REF_W(REF_W)) u_dut (
    .clk(clk), .rst(rst), .seed(seed), .tick(tick), .en(en), .rate(rate),
    .ref_len(ref_len), .load(load), .load_ch(load_ch), .load_seed(load_seed),
    .spike(spike), .num(num)
  );

  pn_spike_bank #(.N(16), .CH(1), .REF_W(REF_W)) u_dut16 (
    .clk(clk), .rst(rst16), .seed(seed16), .tick(tick16), .en(en16), .rate(rate16),
    .ref_len(ref_len16), .load(load16), .load_ch(load_ch16), .load_seed(load_seed16),
    .spike(spike16), .num(num16)
  );

  function automatic logic [31:0] nx32(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] s, input int a);
    if (a == 0) return s;
    return (s << a) | (s >> (32 - a));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input logic [31:0] sd);
    logic [31:0] s;
    s = INIT ^ sd;
    if (s == 32'h0) s = INIT;
    for (int c = 0; c < CH; c++) begin
      m_state[c] = rotl32(s, c);
      m_ref[c]   = 0;
    end
  endtask

  // Expected result of one tick under the current inputs; skip marks a channel being reseeded.
  task automatic model_tick(input int skip, output logic [CH-1:0] sp);
    logic [31:0] nxt;
    sp = '0;
    for (int c = 0; c < CH; c++) begin
      if (c == skip) begin
        m_state[c] = (load_seed == 32'h0) ? INIT : load_seed;
        m_ref[c]   = 0;
      end else begin
        nxt = nx32(m_state[c]);
        if (m_ref[c] != 0) begin
          m_ref[c] = m_ref[c] - 1;
        end else if (en[c] && nxt < rate[c*N +: N]) begin
          sp[c]    = 1'b1;
          m_ref[c] = int'(ref_len);
        end
        m_state[c] = nxt;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; seed = 32'h0; tick = 1'b0;
    step();
    model_reset(32'h0);
    rst = 1'b0;
    n_cmp++;
    if (num[0 +: N] !== 32'h6BCB769C) begin
      n_fail++; $display("FAIL reset_ch0: got %h want 6bcb769c", num[0 +: N]);
    end
    n_cmp++;
    if (num[N +: N] !== 32'hD796ED38) begin
      n_fail++; $display("FAIL reset_ch1: got %h want d796ed38", num[N +: N]);
    end
    n_cmp++;
    if (num[2*N +: N] !== 32'hAF2DDA71) begin
      n_fail++; $display("FAIL reset_ch2: got %h want af2dda71", num[2*N +: N]);
    end
    n_cmp++;
    if (spike !== 3'b000) begin
      n_fail++; $display("FAIL reset_spike: got %b want 000", spike);
    end
    en = '0; rate = '0; tick = 1'b1;
    step();
    tick = 1'b0;
    for (int c = 0; c < CH; c++) m_state[c] = nx32(m_state[c]);
    n_cmp++;
    if (num[0 +: N] !== 32'hD796ED38) begin
      n_fail++; $display("FAIL first_tick_ch0: got %h want d796ed38", num[0 +: N]);
    end
  endtask

  task automatic test_rate_zero();
    logic [CH-1:0] sp;
    int bad = 0;
    en = '1; rate = '0; ref_len = '0; tick = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      model_tick(-1, sp);
      step();
      if (spike !== 3'b000) bad++;
    end
    tick = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rate_zero_spike: %0d cycles with spikes, want 0", bad);
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (num[c*N +: N] !== m_state[c]) begin
        n_fail++; $display("FAIL rate_zero_num ch%0d: got %h want %h", c, num[c*N +: N], m_state[c]);
      end
    end
  endtask

  task automatic test_rate_max();
    logic [CH-1:0] sp;
    int last = -100;
    en = '1; rate = '1; ref_len = '0; tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      model_tick(-1, sp);
      step();
      n_cmp++;
      if (spike !== sp) begin
        n_fail++; $display("FAIL rate_max t%0d: got %b want %b", i, spike, sp);
      end
    end
    ref_len = 4'd3;
    for (int i = 0; i < 24; i++) begin
      model_tick(-1, sp);
      step();
      n_cmp++;
      if (spike !== sp) begin
        n_fail++; $display("FAIL refractory t%0d: got %b want %b", i, spike, sp);
      end
      if (spike[0] === 1'b1) begin
        n_cmp++;
        if (i - last < 4) begin
          n_fail++; $display("FAIL refractory_gap: got %0d want >= 4", i - last);
        end
        last = i;
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_load_refractory();
    logic [CH-1:0] sp;
    rst = 1'b1; seed = 32'h0;
    step();
    rst = 1'b0;
    model_reset(32'h0);
    en = '1; rate = '1; ref_len = 4'd5; tick = 1'b1;
    model_tick(-1, sp);
    step();
    n_cmp++;
    if (spike !== 3'b111) begin
      n_fail++; $display("FAIL load_pre_spike: got %b want 111", spike);
    end
    load = 1'b1; load_ch = 2'd1; load_seed = 32'h0;
    model_tick(1, sp);
    step();
    load = 1'b0;
    n_cmp++;
    if (num[N +: N] !== 32'h6BCB769C) begin
      n_fail++; $display("FAIL load_zero_seed: got %h want 6bcb769c", num[N +: N]);
    end
    n_cmp++;
    if (spike !== 3'b000) begin
      n_fail++; $display("FAIL load_tick_spike: got %b want 000", spike);
    end
    for (int c = 0; c < CH; c += 2) begin
      n_cmp++;
      if (num[c*N +: N] !== m_state[c]) begin
        n_fail++; $display("FAIL load_others ch%0d: got %h want %h", c, num[c*N +: N], m_state[c]);
      end
    end
    model_tick(-1, sp);
    step();
    tick = 1'b0;
    n_cmp++;
    if (spike !== 3'b010) begin
      n_fail++; $display("FAIL load_ref_cleared: got %b want 010", spike);
    end
    load = 1'b1; load_ch = 2'd3; load_seed = 32'h1234_5678;
    step();
    load = 1'b0;
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (num[c*N +: N] !== m_state[c]) begin
        n_fail++; $display("FAIL load_bad_ch ch%0d: got %h want %h", c, num[c*N +: N], m_state[c]);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [CH-1:0] sp;
    en = '1; rate = '1; ref_len = 4'd7; tick = 1'b1;
    model_tick(-1, sp);
    step();
    n_cmp++;
    if (spike !== sp) begin
      n_fail++; $display("FAIL pre_reset_spike: got %b want %b", spike, sp);
    end
    rst = 1'b1; seed = 32'h0000_0001;
    step();
    rst = 1'b0; seed = 32'h0;
    model_reset(32'h1);
    n_cmp++;
    if (spike !== 3'b000) begin
      n_fail++; $display("FAIL reset_clears_spike: got %b want 000", spike);
    end
    n_cmp++;
    if (num[0 +: N] !== 32'h6BCB769D) begin
      n_fail++; $display("FAIL reset_seed1_ch0: got %h want 6bcb769d", num[0 +: N]);
    end
    model_tick(-1, sp);
    step();
    tick = 1'b0;
    n_cmp++;
    if (spike !== 3'b111) begin
      n_fail++; $display("FAIL reset_ref_cleared: got %b want 111", spike);
    end
    n_cmp++;
    if (num[0 +: N] !== 32'hD796ED3B) begin
      n_fail++; $display("FAIL reset_tick_ch0: got %h want d796ed3b", num[0 +: N]);
    end
  endtask

  task automatic test_period16();
    int first_ret = -1;
    int zeros = 0;
    seed16 = 16'h0;
    step();
    rst16 = 1'b0;
    n_cmp++;
    if (num16 !== 16'h769C) begin
      n_fail++; $display("FAIL p16_reset: got %h want 769c", num16);
    end
    tick16 = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      step();
      if (num16 === 16'h0) zeros++;
      if (num16 === 16'h769C && first_ret < 0) first_ret = i;
    end
    tick16 = 1'b0;
    n_cmp++;
    if (first_ret != 65535) begin
      n_fail++; $display("FAIL p16_period: got %0d want 65535", first_ret);
    end
    n_cmp++;
    if (zeros != 0) begin
      n_fail++; $display("FAIL p16_zero_state: got %0d want 0", zeros);
    end
    n_cmp++;
    if (spike16 !== 1'b0) begin
      n_fail++; $display("FAIL p16_spike: got %b want 0", spike16);
    end
  endtask

  initial begin
    rst = 1'b1; seed = '0; tick = 1'b0; load = 1'b0; load_ch = '0; load_seed = '0;
    en = '0; rate = '0; ref_len = '0;
    rst16 = 1'b1; seed16 = '0; tick16 = 1'b0; load16 = 1'b0; load_ch16 = 1'b0;
    load_seed16 = '0; en16 = 1'b0; rate16 = '0; ref_len16 = '0;
    step();
    test_reset();
    test_rate_zero();
    test_rate_max();
    test_load_refractory();
    test_reset_pending();
    test_period16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
